// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU bus bridge: VDP mode codes, bridge FSM states
// and the queued write-access payload.
package vdp_pkg;

    localparam logic [1:0] MODE_REG_SELECT = 2'b00;
    localparam logic [1:0] MODE_REG_DATA   = 2'b01;
    localparam logic [1:0] MODE_VRAM_DATA  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP,
        RD_STROBE,
        RD_HOLD
    } bridge_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } vdp_access_t;

endpackage

// File: rtl/vdp_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes when full and pops when
// empty are ignored.
module vdp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally; count is one bit wider so full and empty stay distinct.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/vdp_bus_bridge.sv
// CPU-side front end for the VDP: queues CPU writes and replays them as clean
// setup/strobe/hold cycles. Define VDP_BUS_BRIDGE_READBACK_EN to enable VDP readback.
module vdp_bus_bridge
    import vdp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned STROBE_CYCLES   = 2,
    parameter int unsigned VRAM_GAP_CYCLES = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    output logic       overflow,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic       vdp_read,
    output logic [7:0] vdp_data_in,
    input  logic [7:0] vdp_data_out
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (STROBE_CYCLES > VRAM_GAP_CYCLES) ? STROBE_CYCLES
                                                                        : VRAM_GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    bridge_state_t    state;
    bridge_state_t    state_next;
    logic [CNT_W-1:0] cnt;
    logic             strobe_done;
    logic             gap_done;

    vdp_access_t      wr_entry;
    vdp_access_t      fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      unused_fifo_count;
    logic             read_pending;

    logic [1:0]       mode_d;
    logic [7:0]       data_d;
    logic [7:0]       rdata_d;
    logic             write_d;
    logic             read_d;
    logic             rvalid_d;

    assign cpu_ready      = !fifo_full && !read_pending;
    assign fifo_push      = cpu_req && cpu_ready && cpu_we;
    assign fifo_pop       = (state == IDLE) && !fifo_empty;
    assign wr_entry.mode  = cpu_addr;
    assign wr_entry.data  = cpu_wdata;
    assign strobe_done    = (cnt == CNT_W'(STROBE_CYCLES - 1));
    assign gap_done       = (cnt == CNT_W'(VRAM_GAP_CYCLES - 1));

    vdp_sync_fifo #(
        .WIDTH ($bits(vdp_access_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

`ifdef VDP_BUS_BRIDGE_READBACK_EN
    logic [1:0] rd_addr;

    // A read blocks further requests until its result has been returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_pending <= 1'b0;
            rd_addr      <= MODE_REG_SELECT;
        end else if (state == RD_HOLD) begin
            read_pending <= 1'b0;
        end else if (cpu_req && cpu_ready && !cpu_we) begin
            read_pending <= 1'b1;
            rd_addr      <= cpu_addr;
        end
    end
`else
    logic unused_data_out;

    assign read_pending    = 1'b0;
    assign unused_data_out = ^vdp_data_out;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase counter restarts on every state change and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                end else if (read_pending) begin
                    state_next = RD_STROBE;
                end
            end
            SETUP:     state_next = STROBE;
            STROBE:    if (strobe_done) state_next = HOLD;
            HOLD:      state_next = (vdp_mode == MODE_VRAM_DATA) ? GAP : IDLE;
            GAP:       if (gap_done) state_next = IDLE;
`ifdef VDP_BUS_BRIDGE_READBACK_EN
            RD_STROBE: if (strobe_done) state_next = RD_HOLD;
            RD_HOLD:   state_next = (vdp_mode == MODE_VRAM_DATA) ? GAP : IDLE;
`endif
            default:   state_next = IDLE;
        endcase
    end

    // Next values of the registered VDP and CPU outputs.
    always_comb begin
        mode_d   = vdp_mode;
        data_d   = vdp_data_in;
        write_d  = (state_next == STROBE);
        read_d   = 1'b0;
        rdata_d  = cpu_rdata;
        rvalid_d = 1'b0;
        if (fifo_pop) begin
            mode_d = fifo_head.mode;
            data_d = fifo_head.data;
        end
`ifdef VDP_BUS_BRIDGE_READBACK_EN
        else if ((state == IDLE) && read_pending) begin
            mode_d = rd_addr;
        end
        read_d = (state_next == RD_STROBE);
        if ((state == RD_STROBE) && strobe_done) begin
            rdata_d = vdp_data_out;
        end
        rvalid_d = (state == RD_HOLD);
`else
        rdata_d  = 8'h00;
        rvalid_d = cpu_req && cpu_ready && !cpu_we;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vdp_mode    <= MODE_REG_SELECT;
            vdp_data_in <= 8'h00;
            vdp_write   <= 1'b0;
            vdp_read    <= 1'b0;
            cpu_rdata   <= 8'h00;
            cpu_rvalid  <= 1'b0;
        end else begin
            vdp_mode    <= mode_d;
            vdp_data_in <= data_d;
            vdp_write   <= write_d;
            vdp_read    <= read_d;
            cpu_rdata   <= rdata_d;
            cpu_rvalid  <= rvalid_d;
        end
    end

    // Sticky record of any request refused while not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cpu_req && !cpu_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vdp_bus_bridge.sv
// Randomised scoreboard bench for vdp_bus_bridge with a toy VDP attached; follows
// VDP_BUS_BRIDGE_READBACK_EN the same way the design does.
module tb_vdp_bus_bridge;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned S     = 2;
    localparam int unsigned G     = 18;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req, cpu_we;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready, cpu_rvalid, overflow;
    logic [7:0] cpu_rdata;
    logic [1:0] vdp_mode;
    logic       vdp_write, vdp_read;
    logic [7:0] vdp_data_in, vdp_data_out;

    vdp_bus_bridge #(
        .FIFO_DEPTH      (DEPTH),
        .STROBE_CYCLES   (S),
        .VRAM_GAP_CYCLES (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .overflow     (overflow),
        .vdp_mode     (vdp_mode),
        .vdp_write    (vdp_write),
        .vdp_read     (vdp_read),
        .vdp_data_in  (vdp_data_in),
        .vdp_data_out (vdp_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic [7:0] data;
    } exp_t;

    exp_t wr_exp[$];
    exp_t rd_exp[$];
    int   pop_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   eng_free = 0;
    int   rd_hold = -1;
    bit   ovf_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Toy VDP: commits on the falling edge of write/read.
    logic [7:0] vram [256];
    logic [7:0] regs [8];
    logic [7:0] sel, vaddr;
    logic       wr_d, rd_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) vram[i] <= 8'h00;
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            sel <= 8'h00; vaddr <= 8'h00; wr_d <= 1'b0; rd_d <= 1'b0;
        end else begin
            if (wr_d && !vdp_write) begin
                case (vdp_mode)
                    2'b00: begin sel <= vdp_data_in; vaddr <= vdp_data_in; end
                    2'b01: regs[sel[2:0]] <= vdp_data_in;
                    2'b10: begin vram[vaddr] <= vdp_data_in; vaddr <= vaddr + 8'd1; end
                    default: ;
                endcase
            end
            if (rd_d && !vdp_read && vdp_mode == 2'b10) vaddr <= vaddr + 8'd1;
            wr_d <= vdp_write;
            rd_d <= vdp_read;
        end
    end

    always_comb begin
        case (vdp_mode)
            2'b00:   vdp_data_out = sel ^ 8'hA5;
            2'b01:   vdp_data_out = regs[sel[2:0]];
            2'b10:   vdp_data_out = vram[vaddr];
            default: vdp_data_out = 8'hFF;
        endcase
    end

    // Reference copy of the VDP state, updated in CPU acceptance order.
    logic [7:0] r_vram [256];
    logic [7:0] r_regs [8];
    logic [7:0] r_sel, r_vaddr;

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) r_vram[i] = 8'h00;
        for (int i = 0; i < 8; i++) r_regs[i] = 8'h00;
        r_sel = 8'h00;
        r_vaddr = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One CPU bus cycle: check ready/overflow, drive a request, record expected replay.
    task automatic step(input bit req, input bit we, input logic [1:0] addr, input logic [7:0] data);
        int c, s;
        logic rdy;
        logic [7:0] rd;
        @(posedge clk);
        #1;
        c = cyc;
        while (pop_q.size() > 0 && pop_q[0] < c) void'(pop_q.pop_front());
        rdy = (pop_q.size() < DEPTH) && !(rd_hold >= c);
        check("cpu_ready", cpu_ready, rdy);
        check("overflow", overflow, ovf_m);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        if (req && !rdy) ovf_m = 1'b1;
        if (req && rdy) begin
            s = (c + 1 > eng_free) ? c + 1 : eng_free;
            if (we) begin
                pop_q.push_back(s);
                wr_exp.push_back('{s + 2, addr, data});
                eng_free = s + 3 + S + ((addr == 2'b10) ? G : 0);
                case (addr)
                    2'b00: begin r_sel = data; r_vaddr = data; end
                    2'b01: r_regs[r_sel[2:0]] = data;
                    2'b10: begin r_vram[r_vaddr] = data; r_vaddr = r_vaddr + 8'd1; end
                    default: ;
                endcase
            end else begin
`ifdef VDP_BUS_BRIDGE_READBACK_EN
                case (addr)
                    2'b00: rd = r_sel ^ 8'hA5;
                    2'b01: rd = r_regs[r_sel[2:0]];
                    2'b10: begin rd = r_vram[r_vaddr]; r_vaddr = r_vaddr + 8'd1; end
                    default: rd = 8'hFF;
                endcase
                rd_hold = s + 1 + S;
                rd_exp.push_back('{s + 2 + S, addr, rd});
                eng_free = s + 2 + S + ((addr == 2'b10) ? G : 0);
`else
                rd = 8'h00;
                rd_exp.push_back('{c + 1, addr, rd});
`endif
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((wr_exp.size() != 0 || rd_exp.size() != 0 || cyc <= eng_free) && n < 3000) begin
            step(1'b0, 1'b0, 2'b00, 8'h00);
            n++;
        end
        check("write queue drained", wr_exp.size(), 0);
        check("read queue drained", rd_exp.size(), 0);
    endtask

    // Monitor: compares every strobe and read response against the scoreboard.
    logic [1:0] pre_mode, rise_mode;
    logic [7:0] pre_data, rise_data;
    logic       wr_prev = 1'b0;
    int         hi_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            wr_prev = 1'b0;
            hi_cnt = 0;
        end else begin
            if (vdp_write && !wr_prev) begin
                if (wr_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected write pulse: got mode %0h data %0h, expected none (cycle %0d)",
                             vdp_mode, vdp_data_in, cyc);
                end else begin
                    e = wr_exp.pop_front();
                    check("write rise cycle", cyc, e.cyc);
                    check("write mode", vdp_mode, e.mode);
                    check("write data", vdp_data_in, e.data);
                    check("setup stable", {pre_mode, pre_data}, {vdp_mode, vdp_data_in});
                end
                rise_mode = vdp_mode;
                rise_data = vdp_data_in;
                hi_cnt = 1;
            end else if (vdp_write) begin
                hi_cnt++;
                check("strobe stable", {vdp_mode, vdp_data_in}, {rise_mode, rise_data});
            end else if (wr_prev) begin
                check("strobe width", hi_cnt, S);
                check("hold stable", {vdp_mode, vdp_data_in}, {rise_mode, rise_data});
            end
            if (cpu_rvalid) begin
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected cpu_rvalid: got rdata %0h, expected none (cycle %0d)", cpu_rdata, cyc);
                end else begin
                    e = rd_exp.pop_front();
                    check("rvalid cycle", cyc, e.cyc);
                    check("cpu_rdata", cpu_rdata, e.data);
`ifdef VDP_BUS_BRIDGE_READBACK_EN
                    check("read mode", vdp_mode, e.mode);
`endif
                end
            end
`ifndef VDP_BUS_BRIDGE_READBACK_EN
            check("vdp_read tied low", vdp_read, 0);
`endif
            wr_prev = vdp_write;
            pre_mode = vdp_mode;
            pre_data = vdp_data_in;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 2'b00; cpu_wdata = 8'h00;
        ref_clear();
        repeat (3) @(posedge clk);
        #2;
        check("reset cpu_ready", cpu_ready, 1);
        check("reset vdp outputs", {vdp_mode, vdp_write, vdp_read, vdp_data_in}, 0);
        check("reset cpu outputs", {cpu_rdata, cpu_rvalid, overflow}, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        eng_free = cyc;

        step(1'b1, 1'b1, 2'b00, 8'h05);
        drain();

        step(1'b1, 1'b1, 2'b10, 8'hAA);
        step(1'b1, 1'b1, 2'b10, 8'hBB);
        step(1'b1, 1'b1, 2'b10, 8'hCC);
        drain();
        check("vram[5]", vram[5], 8'hAA);
        check("vram[6]", vram[6], 8'hBB);
        check("vram[7]", vram[7], 8'hCC);

        // A VRAM write keeps the engine busy while nine more writes arrive.
        step(1'b1, 1'b1, 2'b10, 8'h5A);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 2'b01, 8'(8'h30 + i));
        step(1'b0, 1'b0, 2'b00, 8'h00);
        check("overflow after 9th write", overflow, 1);
        drain();

        step(1'b1, 1'b1, 2'b00, 8'h08);
        step(1'b1, 1'b0, 2'b10, 8'h00);
        drain();
        step(1'b1, 1'b0, 2'b01, 8'h00);
        drain();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 35)
                step(1'b1, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            else
                step(1'b0, 1'b0, 2'b00, 8'h00);
        end
        drain();
        check("vram model agrees", vram[r_vaddr - 8'd1], r_vram[r_vaddr - 8'd1]);

        // Reset during the strobe of the first of four queued register writes.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b01, 8'(8'h40 + i));
        @(posedge clk);
        #1 cpu_req = 1'b0;
        #1 check("mid strobe write high", vdp_write, 1);
        reset = 1'b1;
        #1;
        check("reset drops vdp_write", vdp_write, 0);
        check("reset cpu_ready", cpu_ready, 1);
        wr_exp.delete(); rd_exp.delete(); pop_q.delete();
        rd_hold = -1; ovf_m = 1'b0;
        ref_clear();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        eng_free = cyc;
        repeat (30) step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b1, 2'b01, 8'h77);
        step(1'b1, 1'b0, 2'b00, 8'h00);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
